// File: rtl/sort_phase_scheduler.sv
// sort_phase_scheduler
// Sequencer for the systolic odd-even transposition sort array. A start
// request loads one row into the PEs. The block then runs ROUNDS exchange
// rounds, each one SEND, RECV and CMP cycle. The round parity selects which
// PE group initiates the exchange. A one-cycle done pulse marks the cycle in
// which the array's max output is valid. Every output is a register that is
// decoded from the next state, so each output changes together with the
// state it belongs to.

module sort_phase_scheduler #(
    parameter int ARRAYWIDTH = 8,
    parameter int ROUNDS     = ARRAYWIDTH,
    parameter int RCNT_W     = $clog2(ROUNDS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              write_enable,
    output logic              odd_SL,
    output logic              odd_SR,
    output logic              even_SL,
    output logic              even_SR,
    output logic              odd_RL,
    output logic              odd_RR,
    output logic              even_RL,
    output logic              even_RR,
    output logic              odd_cmp_en,
    output logic              even_cmp_en,
    output logic [RCNT_W-1:0] round
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_RECV,
        S_CMP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic write_enable;
        logic odd_sl;
        logic odd_sr;
        logic even_sl;
        logic even_sr;
        logic odd_rl;
        logic odd_rr;
        logic even_rl;
        logic even_rr;
        logic odd_cmp_en;
        logic even_cmp_en;
    } outs_t;

    localparam logic [RCNT_W-1:0] LAST_ROUND = RCNT_W'(ROUNDS - 1);

    state_t            state_q, state_d;
    logic [RCNT_W-1:0] round_q, round_d;
    outs_t             out_q, out_d;
    logic              in_sort;

    // State, round counter and output registers; async active-low reset clears all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            out_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            state_q <= state_d;
            round_q <= round_d;
            out_q   <= out_d;
        end
    end

    // The sort is "in flight" in the states where abort is honoured.
    assign in_sort = (state_q == S_LOAD) || (state_q == S_SEND) ||
                     (state_q == S_RECV) || (state_q == S_CMP);

    // Next-state and round-counter logic; abort overrides every normal transition.
    always_comb begin
        // NOTE: defaults first, so every path assigns and no latch is inferred.
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            S_IDLE: begin
                round_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SEND;
                round_d = '0;
            end
            S_SEND: state_d = S_RECV;
            S_RECV: state_d = S_CMP;
            S_CMP: begin
                if (round_q < LAST_ROUND) begin
                    state_d = S_SEND;
                    round_d = round_q + RCNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    round_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
        if (abort && in_sort) begin
            state_d = S_IDLE;
            round_d = '0;
        end
    end

    // Output decode of the next state. Parity selects which group sends right.
    always_comb begin
        out_d = '0;
        unique case (state_d)
            S_IDLE: ;
            S_LOAD: begin
                out_d.busy         = 1'b1;
                out_d.write_enable = 1'b1;
            end
            S_SEND: begin
                out_d.busy = 1'b1;
                if (!round_d[0]) begin
                    out_d.odd_sr  = 1'b1;
                    out_d.even_sl = 1'b1;
                end else begin
                    out_d.even_sr = 1'b1;
                    out_d.odd_sl  = 1'b1;
                end
            end
            S_RECV: begin
                out_d.busy = 1'b1;
                if (!round_d[0]) begin
                    out_d.odd_rr  = 1'b1;
                    out_d.even_rl = 1'b1;
                end else begin
                    out_d.even_rr = 1'b1;
                    out_d.odd_rl  = 1'b1;
                end
            end
            S_CMP: begin
                out_d.busy        = 1'b1;
                out_d.odd_cmp_en  = 1'b1;
                out_d.even_cmp_en = 1'b1;
            end
            S_DONE: out_d.done = 1'b1;
            default: out_d = '0;
        endcase
    end

    assign busy         = out_q.busy;
    assign done         = out_q.done;
    assign write_enable = out_q.write_enable;
    assign odd_SL       = out_q.odd_sl;
    assign odd_SR       = out_q.odd_sr;
    assign even_SL      = out_q.even_sl;
    assign even_SR      = out_q.even_sr;
    assign odd_RL       = out_q.odd_rl;
    assign odd_RR       = out_q.odd_rr;
    assign even_RL      = out_q.even_rl;
    assign even_RR      = out_q.even_rr;
    assign odd_cmp_en   = out_q.odd_cmp_en;
    assign even_cmp_en  = out_q.even_cmp_en;
    assign round        = round_q;

endmodule
